// File: rtl/fi_pkg.sv
// Shared encodings for the fault-injection controller: command layout,
// fault type / trigger mode codes, FSM state encoding and a command decoder.
package fi_pkg;

  localparam logic [3:0] FI_COMP_REGFILE = 4'h0;
  localparam logic [3:0] FI_COMP_MEM     = 4'h2;

  localparam int FI_COMP_LSB = 28;
  localparam int FI_TYPE_LSB = 26;
  localparam int FI_MODE_LSB = 24;
  localparam int FI_IDX_LSB  = 19;
  localparam int FI_BIT_LSB  = 14;
  localparam int FI_N_LSB    = 0;

  localparam logic [1:0] FI_TYPE_FLIP = 2'b00;
  localparam logic [1:0] FI_TYPE_SA0  = 2'b01;
  localparam logic [1:0] FI_TYPE_SA1  = 2'b10;

  localparam logic [1:0] FI_MODE_IMM  = 2'b00;
  localparam logic [1:0] FI_MODE_DLY  = 2'b01;
  localparam logic [1:0] FI_MODE_PERS = 2'b10;

  localparam logic [1:0] FI_ST_IDLE   = 2'd0;
  localparam logic [1:0] FI_ST_ARMED  = 2'd1;
  localparam logic [1:0] FI_ST_DELAY  = 2'd2;
  localparam logic [1:0] FI_ST_INJECT = 2'd3;

  typedef struct packed {
    logic [3:0]  comp;
    logic [1:0]  ftype;
    logic [1:0]  mode;
    logic [4:0]  idx;
    logic [4:0]  tbit;
    logic [13:0] n;
  } fi_cmd_t;

  // Reserved codes are folded here so the armed register only ever holds legal ones.
  function automatic fi_cmd_t fi_decode(input logic [31:0] raw);
    fi_cmd_t c;
    c.comp  = raw[FI_COMP_LSB +: 4];
    c.ftype = raw[FI_TYPE_LSB +: 2];
    c.mode  = raw[FI_MODE_LSB +: 2];
    c.idx   = raw[FI_IDX_LSB +: 5];
    c.tbit  = raw[FI_BIT_LSB +: 5];
    c.n     = raw[FI_N_LSB +: 14];
    if (c.ftype == 2'b11) c.ftype = FI_TYPE_FLIP;
    if (c.mode == 2'b11) c.mode = FI_MODE_IMM;
    return c;
  endfunction

endpackage

// File: rtl/fault_injection_ctrl_if.sv
// Command and strobe bundle between the fault-injection controller and its user.
interface fault_injection_ctrl_if #(
  parameter int QUEUE_DEPTH = 4,
  parameter int ADDR_W      = 32,
  parameter int CNT_W       = 8
);
  localparam int LVL_W = $clog2(QUEUE_DEPTH) + 1;

  // Command push is fire-and-forget: each cycle with fault_enable=1 offers one
  // command; there is no ready, a rejected push is reported by cmd_dropped.
  logic              fault_enable;
  logic [31:0]       fault_instruction;
  logic              fault_trigger;
  logic              fault_clear;
  logic              regfile_fault_enable;
  logic [4:0]        regfile_target_reg;
  logic [4:0]        regfile_target_bit;
  logic [1:0]        regfile_fault_type;
  logic              memory_fault_enable;
  logic [ADDR_W-1:0] memory_target_addr;
  logic [4:0]        memory_target_bit;
  logic [1:0]        memory_fault_type;
  logic              fault_active;
  logic [CNT_W-1:0]  fault_count;
  logic [3:0]        fault_component;
  logic [LVL_W-1:0]  queue_level;
  logic              queue_full;
  logic              queue_empty;
  logic              cmd_dropped;
  logic              state_armed;
  logic [1:0]        dbg_state;

  modport master (
    output fault_enable, fault_instruction, fault_trigger, fault_clear,
    input  regfile_fault_enable, regfile_target_reg, regfile_target_bit, regfile_fault_type,
    input  memory_fault_enable, memory_target_addr, memory_target_bit, memory_fault_type,
    input  fault_active, fault_count, fault_component, queue_level, queue_full,
    input  queue_empty, cmd_dropped, state_armed, dbg_state
  );

  modport slave (
    input  fault_enable, fault_instruction, fault_trigger, fault_clear,
    output regfile_fault_enable, regfile_target_reg, regfile_target_bit, regfile_fault_type,
    output memory_fault_enable, memory_target_addr, memory_target_bit, memory_fault_type,
    output fault_active, fault_count, fault_component, queue_level, queue_full,
    output queue_empty, cmd_dropped, state_armed, dbg_state
  );
endinterface

// File: rtl/fi_cmd_fifo.sv
// Synchronous command FIFO with show-ahead read data; the caller gates push
// against full (a same-cycle pop frees a slot) and pop against empty.
module fi_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
endmodule

// File: rtl/fault_injection_ctrl.sv
// Fault-injection controller: queues commands, arms one at a time and drives
// regfile / dmem fault strobes on a trigger (immediate, delayed, persistent).
module fault_injection_ctrl
  import fi_pkg::*;
#(
  parameter int QUEUE_DEPTH = 4,
  parameter int ADDR_W      = 32,
  parameter int CNT_W       = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  fault_injection_ctrl_if.slave bus
);
  localparam int LVL_W = $clog2(QUEUE_DEPTH) + 1;

  logic [1:0]       state;
  fi_cmd_t          armed;
  logic [14:0]      cyc_cnt;
  logic [CNT_W-1:0] inj_count;
  logic             dropped;
  logic             pop;
  logic             push_ok;
  logic             dly_wait;
  logic             enter_inject;
  logic             q_full;
  logic             q_empty;
  logic [31:0]      q_rd_data;
  logic [LVL_W-1:0] q_level;

  assign pop      = (state == FI_ST_IDLE) && !q_empty && !bus.fault_clear;
  assign push_ok  = bus.fault_enable && !bus.fault_clear && (!q_full || pop);
  assign dly_wait = (armed.mode == FI_MODE_DLY) && (armed.n != '0);
  assign enter_inject = !bus.fault_clear &&
                        (((state == FI_ST_ARMED) && bus.fault_trigger && !dly_wait) ||
                         ((state == FI_ST_DELAY) && (cyc_cnt == 15'd1)));

  fi_cmd_fifo #(.DEPTH(QUEUE_DEPTH), .WIDTH(32)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push_ok),
    .pop     (pop),
    .flush   (bus.fault_clear),
    .wr_data (bus.fault_instruction),
    .rd_data (q_rd_data),
    .level   (q_level),
    .full    (q_full),
    .empty   (q_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= FI_ST_IDLE;
      armed     <= '0;
      cyc_cnt   <= '0;
      inj_count <= '0;
      dropped   <= 1'b0;
    end else begin
      dropped <= bus.fault_enable && !bus.fault_clear && q_full && !pop;
      if (enter_inject && (inj_count != '1)) inj_count <= inj_count + CNT_W'(1);
      if (bus.fault_clear) begin
        state   <= FI_ST_IDLE;
        cyc_cnt <= '0;
      end else begin
        case (state)
          FI_ST_IDLE: begin
            if (pop) begin
              armed <= fi_decode(q_rd_data);
              state <= FI_ST_ARMED;
            end
          end
          FI_ST_ARMED: begin
            if (bus.fault_trigger) begin
              if (dly_wait) begin
                cyc_cnt <= {1'b0, armed.n};
                state   <= FI_ST_DELAY;
              end else begin
                // cyc_cnt holds the number of INJECT cycles still to run
                cyc_cnt <= (armed.mode == FI_MODE_PERS) ? ({1'b0, armed.n} + 15'd1) : 15'd1;
                state   <= FI_ST_INJECT;
              end
            end
          end
          FI_ST_DELAY: begin
            if (cyc_cnt == 15'd1) begin
              cyc_cnt <= 15'd1;
              state   <= FI_ST_INJECT;
            end else begin
              cyc_cnt <= cyc_cnt - 15'd1;
            end
          end
          default: begin
            if (cyc_cnt <= 15'd1) begin
              cyc_cnt <= '0;
              state   <= FI_ST_IDLE;
            end else begin
              cyc_cnt <= cyc_cnt - 15'd1;
            end
          end
        endcase
      end
    end
  end

  assign bus.fault_active         = (state == FI_ST_INJECT);
  assign bus.regfile_fault_enable = (state == FI_ST_INJECT) && (armed.comp == FI_COMP_REGFILE);
  assign bus.memory_fault_enable  = (state == FI_ST_INJECT) && (armed.comp == FI_COMP_MEM);
  assign bus.regfile_target_reg   = armed.idx;
  assign bus.regfile_target_bit   = armed.tbit;
  assign bus.regfile_fault_type   = armed.ftype;
  assign bus.memory_target_addr   = ADDR_W'({armed.idx, 2'b00});
  assign bus.memory_target_bit    = armed.tbit;
  assign bus.memory_fault_type    = armed.ftype;
  assign bus.fault_component      = armed.comp;
  assign bus.fault_count          = inj_count;
  assign bus.queue_level          = q_level;
  assign bus.queue_full           = q_full;
  assign bus.queue_empty          = q_empty;
  assign bus.cmd_dropped          = dropped;
  assign bus.state_armed          = (state == FI_ST_ARMED);
  assign bus.dbg_state            = state;
endmodule

// File: tb/tb_fault_injection_ctrl.sv
// Directed bench for fault_injection_ctrl: vector table of single commands plus
// hand sequences for queue overflow, fault_clear, count saturation and reset.
module tb_fault_injection_ctrl;
  localparam int QD = 4;
  localparam int AW = 32;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fault_injection_ctrl_if #(.QUEUE_DEPTH(QD), .ADDR_W(AW), .CNT_W(CW)) bus();

  fault_injection_ctrl #(.QUEUE_DEPTH(QD), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] cmd;
    logic        ren;
    logic        men;
    logic [4:0]  reg_i;
    logic [4:0]  tbit;
    logic [1:0]  ftype;
    logic [31:0] addr;
    logic [3:0]  comp;
    int          first;
    int          len;
  } vec_t;

  vec_t       vecs[8];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_count = 8'd0;
  logic [4:0] exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] mk_cmd(input logic [3:0] comp, input logic [1:0] ft,
                                         input logic [1:0] md, input logic [4:0] idx,
                                         input logic [4:0] tb, input logic [13:0] n);
    return {comp, ft, md, idx, tb, n};
  endfunction

  function automatic logic [7:0] sat8(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  task automatic chk_reset_state(input string tag);
    chk({tag, "_active"},  32'(bus.fault_active), 32'd0);
    chk({tag, "_ren"},     32'(bus.regfile_fault_enable), 32'd0);
    chk({tag, "_men"},     32'(bus.memory_fault_enable), 32'd0);
    chk({tag, "_armed"},   32'(bus.state_armed), 32'd0);
    chk({tag, "_dropped"}, 32'(bus.cmd_dropped), 32'd0);
    chk({tag, "_count"},   32'(bus.fault_count), 32'd0);
    chk({tag, "_empty"},   32'(bus.queue_empty), 32'd1);
    chk({tag, "_level"},   32'(bus.queue_level), 32'd0);
    chk({tag, "_comp"},    32'(bus.fault_component), 32'd0);
    chk({tag, "_reg"},     32'(bus.regfile_target_reg), 32'd0);
    chk({tag, "_addr"},    bus.memory_target_addr, 32'd0);
    chk({tag, "_type"},    32'(bus.memory_fault_type), 32'd0);
    chk({tag, "_state"},   32'(bus.dbg_state), 32'd0);
  endtask

  // Trigger is held high from the push onward: it must be ignored outside ARMED.
  task automatic run_vec(input int id, input vec_t v);
    logic in_win;
    bus.fault_instruction = v.cmd;
    bus.fault_enable = 1'b1;
    bus.fault_trigger = 1'b1;
    tick();
    bus.fault_enable = 1'b0;
    tick();
    chk($sformatf("v%0d_armed", id),  32'(bus.state_armed), 32'd1);
    chk($sformatf("v%0d_preact", id), 32'(bus.fault_active), 32'd0);
    chk($sformatf("v%0d_reg", id),    32'(bus.regfile_target_reg), 32'(v.reg_i));
    chk($sformatf("v%0d_rbit", id),   32'(bus.regfile_target_bit), 32'(v.tbit));
    chk($sformatf("v%0d_rtype", id),  32'(bus.regfile_fault_type), 32'(v.ftype));
    chk($sformatf("v%0d_addr", id),   bus.memory_target_addr, v.addr);
    chk($sformatf("v%0d_mbit", id),   32'(bus.memory_target_bit), 32'(v.tbit));
    chk($sformatf("v%0d_mtype", id),  32'(bus.memory_fault_type), 32'(v.ftype));
    chk($sformatf("v%0d_comp", id),   32'(bus.fault_component), 32'(v.comp));
    tick();
    exp_count = sat8(exp_count);
    for (int c = 0; c < 20; c++) begin
      in_win = (c >= v.first) && (c < v.first + v.len);
      chk($sformatf("v%0d_act_c%0d", id, c), 32'(bus.fault_active), 32'(in_win));
      chk($sformatf("v%0d_ren_c%0d", id, c), 32'(bus.regfile_fault_enable), 32'(in_win && v.ren));
      chk($sformatf("v%0d_men_c%0d", id, c), 32'(bus.memory_fault_enable), 32'(in_win && v.men));
      tick();
    end
    bus.fault_trigger = 1'b0;
    chk($sformatf("v%0d_count", id), 32'(bus.fault_count), 32'(exp_count));
    chk($sformatf("v%0d_idle", id),  32'(bus.state_armed), 32'd0);
    chk($sformatf("v%0d_empty", id), 32'(bus.queue_empty), 32'd1);
  endtask

  initial begin
    bus.fault_enable = 1'b0;
    bus.fault_instruction = 32'd0;
    bus.fault_trigger = 1'b0;
    bus.fault_clear = 1'b0;

    vecs[0] = '{32'h0028_0000, 1'b1, 1'b0, 5'd5, 5'd0, 2'd0, 32'h14, 4'h0, 0, 1};
    vecs[1] = '{mk_cmd(4'h2, 2'd0, 2'd1, 5'd10, 5'd16, 14'd3),
                1'b0, 1'b1, 5'd10, 5'd16, 2'd0, 32'h28, 4'h2, 3, 1};
    vecs[2] = '{mk_cmd(4'h0, 2'd2, 2'd2, 5'd15, 5'd31, 14'd4),
                1'b1, 1'b0, 5'd15, 5'd31, 2'd2, 32'h3C, 4'h0, 0, 5};
    vecs[3] = '{mk_cmd(4'hF, 2'd1, 2'd0, 5'd3, 5'd7, 14'd0),
                1'b0, 1'b0, 5'd3, 5'd7, 2'd1, 32'h0C, 4'hF, 0, 1};
    vecs[4] = '{mk_cmd(4'h2, 2'd3, 2'd1, 5'd31, 5'd5, 14'd0),
                1'b0, 1'b1, 5'd31, 5'd5, 2'd0, 32'h7C, 4'h2, 0, 1};
    vecs[5] = '{mk_cmd(4'h0, 2'd1, 2'd3, 5'd1, 5'd1, 14'd7),
                1'b1, 1'b0, 5'd1, 5'd1, 2'd1, 32'h04, 4'h0, 0, 1};
    vecs[6] = '{mk_cmd(4'h0, 2'd2, 2'd1, 5'd0, 5'd2, 14'd1),
                1'b1, 1'b0, 5'd0, 5'd2, 2'd2, 32'h00, 4'h0, 1, 1};
    vecs[7] = '{mk_cmd(4'h2, 2'd1, 2'd2, 5'd8, 5'd9, 14'd0),
                1'b0, 1'b1, 5'd8, 5'd9, 2'd1, 32'h20, 4'h2, 0, 1};

    rst_n = 1'b0;
    tick();
    tick();
    chk_reset_state("rst0");
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Queue overflow: 4 queued plus 1 armed, the 6th push is dropped.
    exp_q.delete();
    bus.fault_enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.fault_instruction = mk_cmd(4'h0, 2'd0, 2'd0, 5'(i + 1), 5'(i), 14'd0);
      tick();
      if (i < 5) exp_q.push_back(5'(i + 1));
      if (i == 3) chk("q_full_after4", 32'(bus.queue_full), 32'd0);
      if (i == 4) begin
        chk("q_full_after5", 32'(bus.queue_full), 32'd1);
        chk("q_level_after5", 32'(bus.queue_level), 32'd4);
        chk("q_nodrop_after5", 32'(bus.cmd_dropped), 32'd0);
      end
      if (i == 5) chk("q_dropped", 32'(bus.cmd_dropped), 32'd1);
    end
    bus.fault_enable = 1'b0;
    tick();
    chk("q_drop_pulse_end", 32'(bus.cmd_dropped), 32'd0);
    chk("q_level_hold", 32'(bus.queue_level), 32'd4);
    for (int m = 0; m < 5; m++) begin
      chk($sformatf("q%0d_armed", m), 32'(bus.state_armed), 32'd1);
      bus.fault_trigger = 1'b1;
      tick();
      bus.fault_trigger = 1'b0;
      exp_count = sat8(exp_count);
      chk($sformatf("q%0d_ren", m), 32'(bus.regfile_fault_enable), 32'd1);
      if (exp_q.size() == 0) chk($sformatf("q%0d_sb_underflow", m), 32'd1, 32'd0);
      else chk($sformatf("q%0d_reg", m), 32'(bus.regfile_target_reg), 32'(exp_q.pop_front()));
      tick();
      chk($sformatf("q%0d_off", m), 32'(bus.fault_active), 32'd0);
      tick();
    end
    chk("q_drained_empty", 32'(bus.queue_empty), 32'd1);
    chk("q_drained_idle", 32'(bus.state_armed), 32'd0);
    chk("q_count", 32'(bus.fault_count), 32'(exp_count));

    // fault_clear during DELAY with one command queued and a same-cycle push.
    bus.fault_instruction = mk_cmd(4'h2, 2'd0, 2'd1, 5'd4, 5'd4, 14'd5);
    bus.fault_enable = 1'b1;
    tick();
    bus.fault_enable = 1'b0;
    tick();
    bus.fault_trigger = 1'b1;
    tick();
    bus.fault_trigger = 1'b0;
    chk("clr_in_delay", 32'(bus.dbg_state), 32'd2);
    bus.fault_instruction = mk_cmd(4'h0, 2'd0, 2'd0, 5'd1, 5'd1, 14'd0);
    bus.fault_enable = 1'b1;
    tick();
    chk("clr_level_pre", 32'(bus.queue_level), 32'd1);
    bus.fault_clear = 1'b1;
    tick();
    bus.fault_clear = 1'b0;
    bus.fault_enable = 1'b0;
    chk("clr_state", 32'(bus.dbg_state), 32'd0);
    chk("clr_empty", 32'(bus.queue_empty), 32'd1);
    chk("clr_level", 32'(bus.queue_level), 32'd0);
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("clr_act_c%0d", c), 32'(bus.fault_active), 32'd0);
      chk($sformatf("clr_men_c%0d", c), 32'(bus.memory_fault_enable), 32'd0);
      tick();
    end
    chk("clr_no_rearm", 32'(bus.state_armed), 32'd0);
    chk("clr_count_kept", 32'(bus.fault_count), 32'(exp_count));

    // Drive enough immediate injections to pin the counter at all-ones.
    for (int i = 0; i < 256; i++) begin
      bus.fault_instruction = mk_cmd(4'h0, 2'd0, 2'd0, 5'd2, 5'd3, 14'd0);
      bus.fault_enable = 1'b1;
      bus.fault_trigger = 1'b1;
      tick();
      bus.fault_enable = 1'b0;
      tick();
      tick();
      bus.fault_trigger = 1'b0;
      tick();
      exp_count = sat8(exp_count);
    end
    chk("sat_count", 32'(bus.fault_count), 32'(exp_count));
    chk("sat_value", 32'(bus.fault_count), 32'hFF);

    // Reset in the middle of a persistent memory injection.
    bus.fault_instruction = mk_cmd(4'h2, 2'd2, 2'd2, 5'd6, 5'd6, 14'd10);
    bus.fault_enable = 1'b1;
    tick();
    bus.fault_enable = 1'b0;
    tick();
    bus.fault_trigger = 1'b1;
    tick();
    bus.fault_trigger = 1'b0;
    tick();
    chk("rstinj_active", 32'(bus.fault_active), 32'd1);
    chk("rstinj_men", 32'(bus.memory_fault_enable), 32'd1);
    rst_n = 1'b0;
    tick();
    chk_reset_state("rst1");
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("rst1_quiet_c%0d", c), 32'(bus.fault_active), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
